// File: rtl/long_to_double_if.sv
// Operand and result channels of the long-to-double converter.
// A word moves on a rising edge where its stb (valid) and ack (ready) are both high;
// stb holds its data stable until that edge, and neither side takes back a raised stb.
interface long_to_double_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 double: one normalising shift per cycle,
// then round-to-nearest-even. One operand in flight at a time.
module long_to_double (
  input  logic             clk,
  input  logic             rst,
  long_to_double_if.slave  bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT   = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  state_t      state;
  logic [63:0] a;
  logic [63:0] mag;
  logic        sign;
  logic [10:0] exp;
  logic [51:0] m;

  logic [51:0] mant;
  logic        guard;
  logic        rnd;
  logic        sticky;
  logic        round_up;

  // Once mag is normalised its top bit is the hidden one; the next 52 are the mantissa.
  always_comb begin
    mant     = mag[62:11];
    guard    = mag[10];
    rnd      = mag[9];
    sticky   = |mag[8:0];
    round_up = guard && (rnd || sticky || mant[0]);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= GET_A;
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= 64'd0;
      a                <= 64'd0;
      mag              <= 64'd0;
      sign             <= 1'b0;
      exp              <= 11'd0;
      m                <= 52'd0;
    end else begin
      case (state)
        GET_A: begin
          if (bus.input_a_ack && bus.input_a_stb) begin
            a               <= bus.input_a;
            bus.input_a_ack <= 1'b0;
            state           <= CONVERT;
          end else begin
            bus.input_a_ack <= 1'b1;
          end
        end

        CONVERT: begin
          // Negating -2^63 gives 0x8000000000000000, which is the right magnitude unsigned.
          sign <= a[63];
          mag  <= a[63] ? (64'd0 - a) : a;
          exp  <= 11'd63;
          if (a == 64'd0) begin
            bus.output_z     <= 64'd0;
            bus.output_z_stb <= 1'b1;
            state            <= PUT_Z;
          end else begin
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (!mag[63]) begin
            mag <= mag << 1;
            exp <= exp - 11'd1;
          end else begin
            state <= ROUND;
          end
        end

        ROUND: begin
          // An all-ones mantissa that rounds up wraps to zero and bumps the exponent.
          m <= round_up ? (mant + 52'd1) : mant;
          if (round_up && (&mant)) begin
            exp <= exp + 11'd1;
          end
          state <= PACK;
        end

        PACK: begin
          bus.output_z     <= {sign, exp + 11'd1023, m};
          bus.output_z_stb <= 1'b1;
          state            <= PUT_Z;
        end

        PUT_Z: begin
          if (bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= GET_A;
          end
        end

        default: begin
          state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_long_to_double.sv
// Randomised and directed bench for long_to_double, checked against an arithmetic
// model of (double)long with round-to-nearest-even.
module tb_long_to_double;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  long_to_double_if bus ();
  logic [2:0] state_dbg;

  long_to_double dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic        prev_stb = 1'b0;
  logic        prev_ack = 1'b0;
  logic [63:0] prev_z   = 64'd0;
  bit          acc_seen  = 1'b0;
  bit          ack_rand  = 1'b0;
  bit          ack_force = 1'b1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int msb_pos(input logic [63:0] mag);
    int p;
    p = 63;
    while (p > 0 && !mag[p]) p--;
    return p;
  endfunction

  function automatic logic [63:0] abs64(input logic [63:0] x);
    return x[63] ? (64'd0 - x) : x;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] x);
    logic [63:0] mag, q, rem, half;
    int p, sh;
    if (x == 64'd0) return 64'd0;
    mag = abs64(x);
    p = msb_pos(mag);
    if (p <= 52) begin
      q = mag << (52 - p);
    end else begin
      sh   = p - 52;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[53]) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {x[63], 11'(p + 1023), q[51:0]};
  endfunction

  function automatic int model_latency(input logic [63:0] x);
    if (x == 64'd0) return 1;
    return (63 - msb_pos(abs64(x))) + 4;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r >> $urandom_range(0, 63);
    if ($urandom_range(0, 19) == 0) r = 64'd0;
    if ($urandom_range(0, 1) == 1) r = 64'd0 - r;
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
  endtask

  // Compare process: runs every cycle at the falling edge.
  task automatic compare();
    int lat;
    acc_seen = 1'b0;
    if (rst) begin
      prev_stb = 1'b0;
      prev_ack = 1'b0;
      return;
    end
    if (bus.input_a_ack && bus.input_a_stb) begin
      exp_q.push_back(model(bus.input_a));
      lat_q.push_back(model_latency(bus.input_a));
      acc_q.push_back(cyc + 1);
      acc_seen = 1'b1;
    end
    if (bus.output_z_stb && !prev_stb) begin
      if (lat_q.size() == 0 || acc_q.size() == 0) begin
        flag("spurious_stb");
      end else begin
        lat = cyc - acc_q.pop_front();
        check("latency", 64'(lat), 64'(lat_q.pop_front()));
      end
    end
    if (bus.output_z_stb && prev_stb && !prev_ack)
      check("z_stable", bus.output_z, prev_z);
    if (bus.output_z_stb)
      check("ack_low_while_busy", 64'(bus.input_a_ack), 64'd0);
    if (bus.output_z_stb && bus.output_z_ack) begin
      if (exp_q.size() == 0) flag("extra_result");
      else check("result", bus.output_z, exp_q.pop_front());
    end
    prev_stb = bus.output_z_stb;
    prev_ack = bus.output_z_ack;
    prev_z   = bus.output_z;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    #1;
    bus.output_z_ack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_force;
  endtask

  task automatic send(input logic [63:0] x);
    bus.input_a     = x;
    bus.input_a_stb = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (acc_seen) break;
    end
    if (!acc_seen) flag("accept_timeout");
    bus.input_a_stb = 1'b0;
    bus.input_a     = {$urandom, $urandom};
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) cycle();
    if (exp_q.size() != 0) flag("drain_timeout");
  endtask

  logic [63:0] dir_ops[7];

  // ---------------- main sequence ----------------
  initial begin
    bus.input_a      = 64'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_output_z", bus.output_z, 64'd0);
    check("rst_output_z_stb", 64'(bus.output_z_stb), 64'd0);
    check("rst_input_a_ack", 64'(bus.input_a_ack), 64'd0);
    rst = 1'b0;
    #1;
    check("ack_before_first_edge", 64'(bus.input_a_ack), 64'd0);
    cycle();
    check("ack_after_first_edge", 64'(bus.input_a_ack), 64'd1);

    // Hand-computed values pin the model itself.
    check("model_one", model(64'd1), 64'h3FF0000000000000);
    check("model_minus_one", model(64'hFFFFFFFFFFFFFFFF), 64'hBFF0000000000000);
    check("model_zero", model(64'd0), 64'h0000000000000000);
    check("model_min", model(64'h8000000000000000), 64'hC3E0000000000000);
    check("model_max", model(64'h7FFFFFFFFFFFFFFF), 64'h43E0000000000000);
    check("model_tie_down", model(64'h0020000000000001), 64'h4340000000000000);
    check("model_tie_up", model(64'h0020000000000003), 64'h4340000000000002);
    check("model_lat_one", 64'(model_latency(64'd1)), 64'd67);
    check("model_lat_zero", 64'(model_latency(64'd0)), 64'd1);
    check("model_lat_min", 64'(model_latency(64'h8000000000000000)), 64'd4);

    dir_ops[0] = 64'd1;
    dir_ops[1] = 64'hFFFFFFFFFFFFFFFF;
    dir_ops[2] = 64'd0;
    dir_ops[3] = 64'h8000000000000000;
    dir_ops[4] = 64'h7FFFFFFFFFFFFFFF;
    dir_ops[5] = 64'h0020000000000001;
    dir_ops[6] = 64'h0020000000000003;
    ack_force = 1'b1;
    foreach (dir_ops[i]) begin
      send(dir_ops[i]);
      drain();
    end

    // Reset while operand 1 is still normalising.
    send(64'd1);
    repeat (19) cycle();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_output_z_stb", 64'(bus.output_z_stb), 64'd0);
    check("midrst_input_a_ack", 64'(bus.input_a_ack), 64'd0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    check("midrst_ack_before_edge", 64'(bus.input_a_ack), 64'd0);
    cycle();
    check("midrst_ack_after_edge", 64'(bus.input_a_ack), 64'd1);
    send(64'hFFFFFFFFFFFFFF85);
    drain();

    // Backpressure: hold output_z_ack low for 10 cycles.
    ack_force = 1'b0;
    bus.output_z_ack = 1'b0;
    send(64'd12345);
    for (int n = 0; n < 100 && !bus.output_z_stb; n++) cycle();
    if (!bus.output_z_stb) flag("bp_stb_timeout");
    repeat (10) begin
      cycle();
      check("bp_stb_held", 64'(bus.output_z_stb), 64'd1);
      check("bp_input_ack_low", 64'(bus.input_a_ack), 64'd0);
    end
    ack_force = 1'b1;
    bus.output_z_ack = 1'b1;
    cycle();
    check("bp_stb_fall", 64'(bus.output_z_stb), 64'd0);
    check("bp_ack_still_low", 64'(bus.input_a_ack), 64'd0);
    cycle();
    check("bp_ack_rise", 64'(bus.input_a_ack), 64'd1);
    drain();

    // Streaming with random gaps and random downstream ack.
    ack_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) cycle();
      send(rand_op());
    end
    drain();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/long_to_double.md
Name: long_to_double

Overview:
Converts a 64-bit two's-complement signed integer into an IEEE-754 binary64 (double) value.
Sits directly upstream of the output file-writer stage in the long_to_double test harness. It accepts operands over the 64-bit strobe/acknowledge handshake and presents results over the same protocol.
Multi-cycle iterative design: one normalising shift per cycle, round-to-nearest-even.

Parameters:
None (widths fixed: 64-bit integer in, 64-bit double out).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
input_a  input  64  signed integer operand
input_a_stb  input  1  upstream has valid input_a
input_a_ack  output  1  block ready to accept input_a
output_z  output  64  IEEE-754 double result
output_z_stb  output  1  output_z valid
output_z_ack  input  1  downstream accepts output_z

Behaviour:
- Reset (async, rst=1): state=GET_A; input_a_ack=0; output_z_stb=0; output_z=0; internal registers cleared. Applies immediately, including mid-conversion; any in-flight operand is discarded.
- All outputs are registered. input_a_ack first rises on the first clk edge after rst deasserts.
- GET_A:
  - Drive input_a_ack=1.
  - Transfer occurs on an edge where input_a_ack=1 and input_a_stb=1. At that edge: latch a=input_a, drive input_a_ack=0, go to CONVERT.
- CONVERT (1 cycle):
  - sign=a[63]; mag = sign ? -a : a, treated as 64-bit unsigned. -2^63 yields 0x8000000000000000 and is correct.
  - exp=63 (signed, at least 8 bits).
  - If a==0: output_z=0x0000000000000000, output_z_stb=1, go to PUT_Z.
  - Else go to NORMALISE.
- NORMALISE:
  - If mag[63]==0: mag<=mag<<1, exp<=exp-1, stay.
  - Else go to ROUND.
  - Occupies lz+1 cycles, where lz = leading zeros of mag (0..63).
- ROUND (1 cycle):
  - m=mag[62:11] (52 bits); guard=mag[10]; rnd=mag[9]; sticky=|mag[8:0].
  - If guard && (rnd || sticky || m[0]): m<=m+1.
  - If m was all ones before the increment: m wraps to 0 and exp<=exp+1.
- PACK (1 cycle): output_z <= {sign, exp+1023 (11 bits), m}; output_z_stb<=1; go to PUT_Z.
- PUT_Z:
  - Hold output_z and output_z_stb=1 stable until an edge with output_z_ack=1.
  - At that edge: output_z_stb<=0, go to GET_A. input_a_ack rises on the following edge.
- Latency from the accepting edge to the edge that raises output_z_stb:
  - nonzero operand: lz+4 edges (min 4, for |a|≥2^63; max 67, for |a|=1).
  - zero operand: 1 edge.
- Throughput: one operand in flight at a time. input_a_ack=0 throughout CONVERT..PUT_Z.
- Backpressure: output_z_ack is ignored outside PUT_Z. input_a_stb is ignored outside GET_A.
- No overflow, NaN or infinity is possible: the exponent range is 0..63, so biased exponents are 1023..1086.
- Inexact results are rounded silently; there is no flag output.

Test Plan:
- Reset behaviour: assert rst mid-NORMALISE (operand 1, 20 cycles after accept) -> output_z_stb=0 and input_a_ack=0 immediately; after release, input_a_ack=1 one edge later; the next operand converts correctly.
- Basic values: 1 -> 0x3FF0000000000000 at 67 edges after accept; -1 -> 0xBFF0000000000000; 0 -> 0x0000000000000000 at 1 edge.
- Extremes:
  - 0x8000000000000000 (-2^63) -> 0xC3E0000000000000, latency 4.
  - 0x7FFFFFFFFFFFFFFF -> 0x43E0000000000000 (round-up with mantissa carry into exponent).
- Ties-to-even:
  - 0x0020000000000001 (2^53+1) -> 0x4340000000000000 (tie, round down to even).
  - 0x0020000000000003 -> 0x4340000000000002 (tie, round up to even).
- Backpressure: hold output_z_ack=0 for 10 cycles in PUT_Z -> output_z and output_z_stb stable and input_a_ack=0 throughout; ack=1 -> output_z_stb falls next edge, input_a_ack rises one edge later.
- Streaming: 200 random operands with random stb/ack gaps -> every result matches a reference model of (double)long_value under round-to-nearest-even, in order, none dropped or duplicated.
